// File: rtl/ram_rr_arbiter.sv
// Two-requester arbiter sharing one single-port RAM (sync write, async read).
// Each granted request is registered onto the RAM bus for exactly one cycle.
// Read data is captured at the end of that cycle and returned to the owner
// with a one-cycle rvalid pulse.
// Build option: define ARB_FIXED_PRI_EN for fixed priority (requester 0 wins).
// The default build uses round-robin.
module ram_rr_arbiter #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_req0,
   input  logic                       i_req1,
   input  logic                       i_rw0,
   input  logic                       i_rw1,
   input  logic [$clog2(DEPTH)-1:0]   i_addr0,
   input  logic [$clog2(DEPTH)-1:0]   i_addr1,
   input  logic [WIDTH-1:0]           i_wdata0,
   input  logic [WIDTH-1:0]           i_wdata1,
   output logic                       o_gnt0,
   output logic                       o_gnt1,
   output logic [WIDTH-1:0]           o_rdata0,
   output logic [WIDTH-1:0]           o_rdata1,
   output logic                       o_rvalid0,
   output logic                       o_rvalid1,
   output logic                       o_ram_rw,
   output logic [$clog2(DEPTH)-1:0]   o_ram_addr,
   output logic [WIDTH-1:0]           o_ram_wdata,
   input  logic [WIDTH-1:0]           i_ram_rdata
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StServe0 = 2'd1,
      StServe1 = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_d;
   logic             r_ram_rw;
   logic [AW-1:0]    r_ram_addr;
   logic [WIDTH-1:0] r_ram_wdata;
   logic [WIDTH-1:0] r_rdata0;
   logic [WIDTH-1:0] r_rdata1;
   logic             r_rvalid0;
   logic             r_rvalid1;
   logic             w_rd_done0;
   logic             w_rd_done1;

`ifndef ARB_FIXED_PRI_EN
   // Last requester served; resets to 1 so requester 0 wins the first tie.
   logic             r_last;
`endif

   // Next-state selection.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
`ifdef ARB_FIXED_PRI_EN
            if (i_req0) begin
               w_state_d = StServe0;
            end else if (i_req1) begin
               w_state_d = StServe1;
            end else begin
               w_state_d = StIdle;
            end
`else
            if (i_req0 && i_req1) begin
               w_state_d = r_last ? StServe0 : StServe1;
            end else if (i_req0) begin
               w_state_d = StServe0;
            end else if (i_req1) begin
               w_state_d = StServe1;
            end else begin
               w_state_d = StIdle;
            end
`endif
         end
         // The served requester's req is still high this cycle, so it is ignored
         // here except where fixed priority needs it.
         StServe0: begin
`ifdef ARB_FIXED_PRI_EN
            w_state_d = (i_req1 && !i_req0) ? StServe1 : StIdle;
`else
            w_state_d = i_req1 ? StServe1 : StIdle;
`endif
         end
         StServe1: begin
            w_state_d = i_req0 ? StServe0 : StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

`ifndef ARB_FIXED_PRI_EN
   // Remember the requester entering service for the next tie-break.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if (w_state_d == StServe0) begin
         r_last <= 1'b0;
      end else if (w_state_d == StServe1) begin
         r_last <= 1'b1;
      end
   end
`endif

   // RAM bus registers: load on entering a serve state; clear rw on entering idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_rw    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
      end else begin
         case (w_state_d)
            StServe0: begin
               r_ram_rw    <= i_rw0;
               r_ram_addr  <= i_addr0;
               r_ram_wdata <= i_wdata0;
            end
            StServe1: begin
               r_ram_rw    <= i_rw1;
               r_ram_addr  <= i_addr1;
               r_ram_wdata <= i_wdata1;
            end
            default: begin
               r_ram_rw    <= 1'b0;
            end
         endcase
      end
   end

   // A read access completes at the edge ending its serve cycle.
   always_comb begin
      w_rd_done0 = (r_state == StServe0) && !r_ram_rw;
      w_rd_done1 = (r_state == StServe1) && !r_ram_rw;
   end

   // Capture read data for the owner; rdata holds until that owner's next read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata0  <= '0;
         r_rdata1  <= '0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_rd_done0;
         r_rvalid1 <= w_rd_done1;
         if (w_rd_done0) begin
            r_rdata0 <= i_ram_rdata;
         end
         if (w_rd_done1) begin
            r_rdata1 <= i_ram_rdata;
         end
      end
   end

   // Output decode: grants straight from state, everything else registered.
   always_comb begin
      o_gnt0      = (r_state == StServe0);
      o_gnt1      = (r_state == StServe1);
      o_rdata0    = r_rdata0;
      o_rdata1    = r_rdata1;
      o_rvalid0   = r_rvalid0;
      o_rvalid1   = r_rvalid1;
      o_ram_rw    = r_ram_rw;
      o_ram_addr  = r_ram_addr;
      o_ram_wdata = r_ram_wdata;
   end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Two-requester round-robin arbiter sharing one single-port RAM (synchronous write, asynchronous read) between requesters 0 and 1.
- Registers each winning request onto the RAM bus for one access cycle, captures read data, and returns it to the owning requester.
- Sits between two client blocks and the single-port RAM module, which continues to own the storage.

Parameters:
- WIDTH, 2, data width in bits.
- DEPTH, 8, number of RAM locations.
- AW = $clog2(DEPTH) is derived (localparam), not overridable.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request from requester 0 / 1.
- rw0 / rw1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  AW  requester address.
- wdata0 / wdata1  in  WIDTH  requester write data.
- gnt0 / gnt1  out  1  high for exactly the one cycle the access is on the RAM bus.
- rdata0 / rdata1  out  WIDTH  captured read data; holds until the next read by that requester.
- rvalid0 / rvalid1  out  1  one-cycle pulse, the cycle after a read grant.
- ram_rw  out  1  to RAM rw; 1 = write.
- ram_addr  out  AW  to RAM addr.
- ram_wdata  out  WIDTH  to RAM indata.
- ram_rdata  in  WIDTH  from RAM outdata; combinational read.

Behaviour:
- Reset: asynchronous, asserted while rst_n = 0.
  - State = IDLE; last = 1, so requester 0 wins the first tie.
  - All outputs 0: gnt*, rvalid*, rdata*, ram_rw, ram_addr, ram_wdata.
  - Reset mid-access aborts that access with no write. Requesters must re-request.
- Requester rules:
  - Hold req, rw, addr and wdata stable until gnt is sampled high.
  - Drop req, or present a new request, the cycle after gnt.
- FSM states: IDLE, SERVE0, SERVE1.
  - IDLE, no req: stay in IDLE.
  - IDLE, one req: go to SERVE of that requester.
  - IDLE, both req: go to SERVE of the requester != last.
  - SERVEx: req_x is ignored, since it is still high that cycle. If the other requester has req high, go to its SERVE (back-to-back). Otherwise go to IDLE.
  - On entering SERVEx: last <= x.
- RAM bus:
  - On the edge entering SERVEx, ram_rw, ram_addr and ram_wdata are loaded from requester x. These outputs are registered, with no combinational path from requester inputs.
  - On any edge entering IDLE, ram_rw <= 0. ram_addr and ram_wdata hold. No write ever occurs outside SERVE.
- Grant: gnt_x = (state == SERVEx), decoded from state. At most one gnt is high in any cycle.
- Write: the RAM stores at the posedge ending the SERVEx cycle.
- Read:
  - ram_rdata is captured into rdata_x at the posedge ending SERVEx.
  - rvalid_x pulses high the following cycle.
  - Read latency from gnt_x to rvalid_x is 1 cycle; from req_x assertion to rvalid_x it is 2 cycles minimum.
- Throughput:
  - A single requester gets 1 access per 2 cycles (SERVE, IDLE).
  - Both requesting continuously: strict alternation, 1 access per cycle, SERVE0 and SERVE1 back-to-back.
- Same address:
  - A read in SERVE1 after a write in SERVE0 to the same address returns the new data.
  - Within one access there is no read-during-write; a write access never produces rvalid.

Optional Feature:
- Macro: ARB_FIXED_PRI_EN.
- Defined:
  - In IDLE with both requests, requester 0 always wins.
  - From SERVE1, go to SERVE0 if req0 is high, else IDLE.
  - From SERVE0, go to SERVE1 only if req1 is high and req0 is low at that edge (the cycle after a grant). Otherwise go to IDLE, and requester 0 wins again from IDLE if both request.
  - The last register is not used.
- Undefined: round-robin exactly as in Behaviour.

Test Plan:
- Reset: rst_n = 0 mid-SERVE0 with rw0 = 1, addr0 = 3, wdata0 = 2'b11 → all outputs 0 immediately. A later read of addr 3 does not return 2'b11 unless that location was written before.
- Single writer: req0 with rw0 = 1 to addrs 0..7, data = addr[1:0] → one gnt0 every 2 cycles, ram_rw = 1 only during gnt0, 8 grants.
- Single reader: req1 with rw1 = 0 to addrs 0..7 after the above writes → rvalid1 one cycle after each gnt1, rdata1 = addr[1:0].
- Contention: req0 and req1 both held for 4 accesses each, from reset → gnt sequence 0,1,0,1,0,1,0,1 on consecutive cycles, never both high.
- Write-then-read: req0 writes 2'b10 to addr 5 while req1 reads addr 5 in the same cycle → gnt0 then gnt1, rdata1 = 2'b10.
- With ARB_FIXED_PRI_EN:
  - req1 held from cycle 0; req0 held for 3 accesses, first presented in the same cycle as req1 → 3 gnt0 precede the first gnt1.
  - req0 held continuously → gnt1 never.
